// File: rtl/sram_like_arbiter.sv
// Two-master (I-cache / D-cache) to one SRAM-like slave arbiter, one transaction outstanding.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data has fixed priority.
module sram_like_arbiter #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic [31:0] rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        grant;
  logic        pick_data;
  logic        gnt_data;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  assign grant = (state == IDLE) && (inst_req || data_req);

`ifdef ARB_ROUND_ROBIN_EN
  // last_data = 1 means the D-cache won the most recent grant.
  logic last_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_data <= (RR_INIT != 0);
    end else if (grant) begin
      last_data <= pick_data;
    end
  end

  assign pick_data = data_req && (!inst_req || !last_data);
`else
  logic unused_rr_init;
  assign unused_rr_init = (RR_INIT != 0);
  assign pick_data      = data_req;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the request latches are reset too, so a reset mid-transaction
  // leaves no stale address/data visible on the mem_* bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_data  <= 1'b0;
      lat_wr    <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (grant) begin
      gnt_data  <= pick_data;
      lat_wr    <= pick_data ? data_wr    : 1'b0;
      lat_size  <= pick_data ? data_size  : 2'd2;
      lat_addr  <= pick_data ? data_addr  : inst_addr;
      lat_wdata <= pick_data ? data_wdata : 32'd0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;

    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          inst_addr_ok = !gnt_data;
          data_addr_ok = gnt_data;
          // A slave may accept and complete in the same cycle.
          if (mem_data_ok) begin
            inst_data_ok = !gnt_data;
            data_data_ok = gnt_data;
            state_nxt    = IDLE;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          inst_data_ok = !gnt_data;
          data_data_ok = gnt_data;
          state_nxt    = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign mem_wr    = lat_wr;
  assign mem_size  = lat_size;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: stimulus queues expected address/data
// handshakes, a negedge monitor pops and compares whenever a *_ok pulse appears.
module tb_sram_like_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  sram_like_arbiter #(.RR_INIT(0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .rdata        (rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } addr_exp_t;

  typedef struct {
    logic        is_data;
    logic        chk_rdata;
    logic [31:0] rdata;
  } data_exp_t;

  addr_exp_t addr_q[$];
  data_exp_t data_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_addr(input logic is_data, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    addr_exp_t e;
    e.is_data = is_data;
    e.wr      = wr;
    e.size    = size;
    e.addr    = addr;
    e.wdata   = wdata;
    addr_q.push_back(e);
  endtask

  task automatic exp_data(input logic is_data, input logic chk_rdata, input logic [31:0] rd);
    data_exp_t e;
    e.is_data   = is_data;
    e.chk_rdata = chk_rdata;
    e.rdata     = rd;
    data_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    addr_exp_t ae;
    data_exp_t de;
    if (inst_addr_ok || data_addr_ok) begin
      if (addr_q.size() == 0) begin
        check("unexpected_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd0);
      end else begin
        ae = addr_q.pop_front();
        check("addr_ok_who", {62'd0, inst_addr_ok, data_addr_ok},
              ae.is_data ? 64'd1 : 64'd2);
        check("addr_mem_req",   {63'd0, mem_req},   64'd1);
        check("addr_mem_wr",    {63'd0, mem_wr},    {63'd0, ae.wr});
        check("addr_mem_size",  {62'd0, mem_size},  {62'd0, ae.size});
        check("addr_mem_addr",  {32'd0, mem_addr},  {32'd0, ae.addr});
        check("addr_mem_wdata", {32'd0, mem_wdata}, {32'd0, ae.wdata});
      end
    end
    if (inst_data_ok || data_data_ok) begin
      if (data_q.size() == 0) begin
        check("unexpected_data_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
      end else begin
        de = data_q.pop_front();
        check("data_ok_who", {62'd0, inst_data_ok, data_data_ok},
              de.is_data ? 64'd1 : 64'd2);
        if (de.chk_rdata) begin
          check("data_rdata", {32'd0, rdata}, {32'd0, de.rdata});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b0;
    inst_addr   = 32'd0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = 32'd0;
    data_wdata  = 32'd0;
    mem_rdata   = 32'h1234_5678;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;

    // Reset state, with the slave handshakes held high to prove they are ignored.
    tick();
    tick();
    check("rst_mem_req",      {63'd0, mem_req},      64'd0);
    check("rst_inst_addr_ok", {63'd0, inst_addr_ok}, 64'd0);
    check("rst_data_addr_ok", {63'd0, data_addr_ok}, 64'd0);
    check("rst_inst_data_ok", {63'd0, inst_data_ok}, 64'd0);
    check("rst_data_data_ok", {63'd0, data_data_ok}, 64'd0);
    check("rst_mem_addr",     {32'd0, mem_addr},     64'd0);
    check("rst_rdata_pass",   {32'd0, rdata},        64'h1234_5678);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    resetn      = 1'b1;
    tick();

    // Both requesters continuously active, slave always ready: 4 grants in 8 cycles.
    inst_addr   = 32'h0000_1000;
    data_addr   = 32'h0000_2000;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_wdata  = 32'h0000_0055;
    mem_rdata   = 32'hA5A5_0001;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i % 2 == 0) begin
        exp_addr(1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'h0000_0055);
        exp_data(1'b1, 1'b1, 32'hA5A5_0001);
      end else begin
        exp_addr(1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0);
        exp_data(1'b0, 1'b1, 32'hA5A5_0001);
      end
`else
      exp_addr(1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'h0000_0055);
      exp_data(1'b1, 1'b1, 32'hA5A5_0001);
`endif
    end
    inst_req    = 1'b1;
    data_req    = 1'b1;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    repeat (8) tick();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    tick();
    tick();
    check("stream_addr_q_drained", 64'(addr_q.size()), 64'd0);

    // Boot fetch: slow address accept, data two cycles later.
    exp_addr(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
    exp_data(1'b0, 1'b1, 32'h3C1D_8000);
    inst_addr = 32'hBFC0_0000;
    inst_req  = 1'b1;
    tick();
    inst_req  = 1'b0;
    inst_addr = 32'hDEAD_0000;
    check("fetch_latency_mem_req", {63'd0, mem_req}, 64'd1);
    tick();
    tick();
    check("fetch_hold_mem_addr", {32'd0, mem_addr}, 64'hBFC0_0000);
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    check("fetch_data_mem_req", {63'd0, mem_req}, 64'd0);
    tick();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h3C1D_8000;
    tick();
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    tick();
    tick();

    // Halfword write; requester changes its inputs right after grant.
    exp_addr(1'b1, 1'b1, 2'd1, 32'h8000_1004, 32'h0000_BEEF);
    exp_data(1'b1, 1'b0, 32'h0);
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd1;
    data_addr  = 32'h8000_1004;
    data_wdata = 32'h0000_BEEF;
    tick();
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    tick();
    mem_data_ok = 1'b0;
    tick();
    tick();

    // Reset while waiting for data: the late mem_data_ok must not surface.
    exp_addr(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
    inst_addr = 32'h0000_0100;
    inst_req  = 1'b1;
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("rstmid_mem_req",      {63'd0, mem_req},      64'd0);
    check("rstmid_inst_data_ok", {63'd0, inst_data_ok}, 64'd0);
    check("rstmid_mem_addr",     {32'd0, mem_addr},     64'd0);
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_0BAD;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    mem_data_ok = 1'b0;
    check("rstmid_idle_mem_req", {63'd0, mem_req}, 64'd0);

    exp_addr(1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0);
    exp_data(1'b0, 1'b1, 32'h0000_600D);
    inst_addr = 32'h0000_0200;
    inst_req  = 1'b1;
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_600D;
    tick();
    mem_data_ok = 1'b0;
    tick();
    tick();

    check("final_addr_q_empty", 64'(addr_q.size()), 64'd0);
    check("final_data_q_empty", 64'(data_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
